// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type and palette for the pixel-generation stage.
package vga_pkg;

   localparam int unsigned H_RES = 640;
   localparam int unsigned V_RES = 480;

   typedef struct packed {
      logic [9:0] r;
      logic [9:0] g;
      logic [9:0] b;
   } cor_t;

   // Entry 0 is the rightmost element: white, red, green, yellow.
   localparam cor_t [3:0] PALETA = {
      cor_t'{r: 10'h3FF, g: 10'h3FF, b: 10'h000},
      cor_t'{r: 10'h000, g: 10'h3FF, b: 10'h000},
      cor_t'{r: 10'h3FF, g: 10'h000, b: 10'h000},
      cor_t'{r: 10'h3FF, g: 10'h3FF, b: 10'h3FF}
   };

   localparam cor_t FUNDO = cor_t'{r: 10'h040, g: 10'h0C0, b: 10'h1C0};

endpackage

// File: rtl/quadrado_animado_if.sv
// Timing-generator inputs and RGB/sync outputs of the animated-square stage.
interface quadrado_animado_if;

   logic       enable;
   logic [9:0] sx;
   logic [9:0] sy;
   logic       hsync_in;
   logic       vsync_in;
   logic       de_in;
   logic [9:0] vga_r;
   logic [9:0] vga_g;
   logic [9:0] vga_b;
   logic       hsync_out;
   logic       vsync_out;
   logic       de_out;
   logic [7:0] batidas;

   modport master (
      output enable, sx, sy, hsync_in, vsync_in, de_in,
      input  vga_r, vga_g, vga_b, hsync_out, vsync_out, de_out, batidas
   );

   modport slave (
      input  enable, sx, sy, hsync_in, vsync_in, de_in,
      output vga_r, vga_g, vga_b, hsync_out, vsync_out, de_out, batidas
   );

endinterface

// File: rtl/eixo_quique.sv
// One axis of the bouncing square: position and direction, stepped once per frame tick.
module eixo_quique #(
   parameter int unsigned LIMITE      = 600,
   parameter int unsigned VEL         = 2,
   parameter int unsigned POS_INICIAL = 300
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       passo,
   output logic [9:0] pos,
   output logic       bateu
);

   localparam logic [10:0] Limite  = 11'(LIMITE);
   localparam logic [10:0] Vel     = 11'(VEL);
   localparam logic [10:0] PosIni  = 11'(POS_INICIAL);

   logic [10:0] pos_q, pos_d;
   logic        dir_q, dir_d;

   // 11-bit arithmetic so pos + VEL cannot wrap before the edge compare.
   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      bateu = 1'b0;
      if (passo) begin
         if (dir_q) begin
            if (pos_q + Vel >= Limite) begin
               pos_d = Limite;
               dir_d = 1'b0;
               bateu = 1'b1;
            end else begin
               pos_d = pos_q + Vel;
            end
         end else begin
            if (pos_q <= Vel) begin
               pos_d = '0;
               dir_d = 1'b1;
               bateu = 1'b1;
            end else begin
               pos_d = pos_q - Vel;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pos_q <= PosIni;
         dir_q <= 1'b1;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign pos = pos_q[9:0];

endmodule

// File: rtl/quadrado_animado.sv
// Draws a bouncing square over a fixed background; RGB and sync leave one cycle after input.
module quadrado_animado #(
   parameter int unsigned H_RES = vga_pkg::H_RES,
   parameter int unsigned V_RES = vga_pkg::V_RES,
   parameter int unsigned LADO  = 40,
   parameter int unsigned VEL_X = 2,
   parameter int unsigned VEL_Y = 1
) (
   input logic               clock,
   input logic               reset_n,
   quadrado_animado_if.slave bus
);

   localparam int unsigned LimX = H_RES - LADO;
   localparam int unsigned LimY = V_RES - LADO;

   logic        fim_quadro, passo, dentro;
   logic        bateu_x, bateu_y;
   logic [9:0]  pos_x, pos_y;
   logic [10:0] sx_ext, sy_ext, px_ext, py_ext;

   logic [1:0]        cor_idx_q, cor_idx_d;
   logic [7:0]        batidas_q, batidas_d;
   vga_pkg::cor_t     rgb_q, rgb_d;
   logic              hsync_q, vsync_q, de_q;

   assign fim_quadro = (bus.sx == 10'd0) && (bus.sy == 10'(V_RES));
   assign passo      = fim_quadro & bus.enable;

   eixo_quique #(
      .LIMITE      (LimX),
      .VEL         (VEL_X),
      .POS_INICIAL (LimX / 2)
   ) u_eixo_x (
      .clock   (clock),
      .reset_n (reset_n),
      .passo   (passo),
      .pos     (pos_x),
      .bateu   (bateu_x)
   );

   eixo_quique #(
      .LIMITE      (LimY),
      .VEL         (VEL_Y),
      .POS_INICIAL (LimY / 2)
   ) u_eixo_y (
      .clock   (clock),
      .reset_n (reset_n),
      .passo   (passo),
      .pos     (pos_y),
      .bateu   (bateu_y)
   );

   assign sx_ext = {1'b0, bus.sx};
   assign sy_ext = {1'b0, bus.sy};
   assign px_ext = {1'b0, pos_x};
   assign py_ext = {1'b0, pos_y};

   // Uses the pre-update position, so a tick never changes the pixel it lands on.
   assign dentro = (sx_ext >= px_ext) && (sx_ext < px_ext + 11'(LADO)) &&
                   (sy_ext >= py_ext) && (sy_ext < py_ext + 11'(LADO));

   always_comb begin
      cor_idx_d = cor_idx_q;
      batidas_d = batidas_q;
      if (bateu_x || bateu_y) begin
         cor_idx_d = cor_idx_q + 2'd1;
         batidas_d = batidas_q + 8'd1;
      end
      if (!bus.de_in) begin
         rgb_d = '0;
      end else if (dentro) begin
         rgb_d = vga_pkg::PALETA[cor_idx_q];
      end else begin
         rgb_d = vga_pkg::FUNDO;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cor_idx_q <= '0;
         batidas_q <= '0;
         rgb_q     <= '0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         de_q      <= 1'b0;
      end else begin
         cor_idx_q <= cor_idx_d;
         batidas_q <= batidas_d;
         rgb_q     <= rgb_d;
         hsync_q   <= bus.hsync_in;
         vsync_q   <= bus.vsync_in;
         de_q      <= bus.de_in;
      end
   end

   assign bus.vga_r     = rgb_q.r;
   assign bus.vga_g     = rgb_q.g;
   assign bus.vga_b     = rgb_q.b;
   assign bus.hsync_out = hsync_q;
   assign bus.vsync_out = vsync_q;
   assign bus.de_out    = de_q;
   assign bus.batidas   = batidas_q;

endmodule
